// File: rtl/mult_wb_ctrl.sv
// Writeback controller behind the execute stage. ALU results are registered straight into
// writeback; multiplies are started with a doMult pulse and retired when execute reports mult_done.
module mult_wb_ctrl #(
   parameter int unsigned TIMEOUT = 64,  // WAIT cycles before abort, 2..255
   parameter int unsigned CW      = 8    // watchdog width, 2**CW > TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [5:0]  ALU_ctr,
   input  logic        reg_wr,
   input  logic [4:0]  rd,
   input  logic [31:0] exec_out,
   input  logic        mult_done,
   output logic        doMult,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mult_err,
   output logic [1:0]  dbg_state
);

   // Handshake: doMult is a one-cycle start pulse; mult_done is a level that only counts in
   // WAIT; stall holds PC/decode (and ALU_ctr) stable from acceptance until done is seen.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   state_e        state_q,    state_d;
   logic          do_mult_q,  do_mult_d;
   logic          wb_en_q,    wb_en_d;
   logic [4:0]    wb_rd_q,    wb_rd_d;
   logic [31:0]   wb_data_q,  wb_data_d;
   logic          mult_err_q, mult_err_d;
   logic [4:0]    held_rd_q,  held_rd_d;
   logic          held_wr_q,  held_wr_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic          is_mult;

   assign is_mult = (ALU_ctr == 6'h0e) | (ALU_ctr == 6'h16);

   always_comb begin
      state_d    = state_q;
      wb_en_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      mult_err_d = mult_err_q;
      held_rd_d  = held_rd_q;
      held_wr_d  = held_wr_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               if (is_mult) begin
                  held_rd_d = rd;
                  held_wr_d = reg_wr;
                  cnt_d     = '0;
                  state_d   = S_ISSUE;
               end else begin
                  wb_data_d = exec_out;
                  wb_rd_d   = rd;
                  wb_en_d   = reg_wr;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mult_done) begin
               wb_data_d = exec_out;
               wb_rd_d   = held_rd_q;
               wb_en_d   = held_wr_q;
               state_d   = S_IDLE;
            end else if (cnt_q == LAST_CNT) begin
               mult_err_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      do_mult_d = (state_d == S_ISSUE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         do_mult_q  <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         mult_err_q <= 1'b0;
         held_rd_q  <= '0;
         held_wr_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         do_mult_q  <= do_mult_d;
         wb_en_q    <= wb_en_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         mult_err_q <= mult_err_d;
         held_rd_q  <= held_rd_d;
         held_wr_q  <= held_wr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Stall releases in the same cycle done is seen so the next instruction follows at once.
   assign stall = ((state_q == S_IDLE) & instr_valid & is_mult) |
                  (state_q == S_ISSUE) |
                  ((state_q == S_WAIT) & ~mult_done);

   assign doMult    = do_mult_q;
   assign wb_en     = wb_en_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign mult_err  = mult_err_q;
   assign dbg_state = state_q;

   a_domult_pulse: assert property (@(posedge clk) disable iff (reset) doMult |=> !doMult);
   a_err_sticky:   assert property (@(posedge clk) disable iff (reset) mult_err |=> mult_err);

endmodule

// File: tb/tb_mult_wb_ctrl.sv
// Bench for mult_wb_ctrl: two instances (default watchdog and an 8-cycle watchdog) share the
// stimulus bus; a per-instance expected-writeback queue is drained by negedge monitors.
module tb_mult_wb_ctrl;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic [5:0]  ALU_ctr;
   logic        reg_wr;
   logic [4:0]  rd;
   logic [31:0] exec_out;
   logic        mult_done;
   bit          sel;

   logic        iv0, iv1, md0, md1;
   logic        domult0, stall0, wb_en0, err0;
   logic        domult1, stall1, wb_en1, err1;
   logic [4:0]  wb_rd0, wb_rd1;
   logic [31:0] wb_data0, wb_data1;
   logic [1:0]  dbg0, dbg1;
   logic        cur_stall, cur_domult, cur_err;

   logic [36:0] exp_q0[$];
   logic [36:0] exp_q1[$];
   bit          err_exp[2];
   int          n_checks;
   int          n_errors;

   assign iv0 = instr_valid & ~sel;
   assign iv1 = instr_valid & sel;
   assign md0 = mult_done & ~sel;
   assign md1 = mult_done & sel;
   assign cur_stall  = sel ? stall1  : stall0;
   assign cur_domult = sel ? domult1 : domult0;
   assign cur_err    = sel ? err1    : err0;

   mult_wb_ctrl u_dut0 (
      .clk(clk), .reset(reset), .instr_valid(iv0), .ALU_ctr(ALU_ctr), .reg_wr(reg_wr),
      .rd(rd), .exec_out(exec_out), .mult_done(md0), .doMult(domult0), .stall(stall0),
      .wb_en(wb_en0), .wb_rd(wb_rd0), .wb_data(wb_data0), .mult_err(err0), .dbg_state(dbg0)
   );

   mult_wb_ctrl #(.TIMEOUT(8), .CW(4)) u_dut1 (
      .clk(clk), .reset(reset), .instr_valid(iv1), .ALU_ctr(ALU_ctr), .reg_wr(reg_wr),
      .rd(rd), .exec_out(exec_out), .mult_done(md1), .doMult(domult1), .stall(stall1),
      .wb_en(wb_en1), .wb_rd(wb_rd1), .wb_data(wb_data1), .mult_err(err1), .dbg_state(dbg1)
   );

   // Clock / safety bound
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL sim_timeout: simulation did not finish within the time bound");
      $fatal(1, "time bound expired");
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: every writeback must match the oldest outstanding retirement.
   always @(negedge clk) begin
      logic [36:0] e;
      if (wb_en0 === 1'b1) begin
         if (exp_q0.size() == 0) chk1("wb0_unexpected", 1'b1, 1'b0);
         else begin
            e = exp_q0.pop_front();
            chk32("wb0_rd", {27'd0, wb_rd0}, {27'd0, e[36:32]});
            chk32("wb0_data", wb_data0, e[31:0]);
         end
      end
      if (wb_en1 === 1'b1) begin
         if (exp_q1.size() == 0) chk1("wb1_unexpected", 1'b1, 1'b0);
         else begin
            e = exp_q1.pop_front();
            chk32("wb1_rd", {27'd0, wb_rd1}, {27'd0, e[36:32]});
            chk32("wb1_data", wb_data1, e[31:0]);
         end
      end
   end

   task automatic push_exp(input logic [4:0] r, input logic [31:0] d);
      if (sel) exp_q1.push_back({r, d});
      else     exp_q0.push_back({r, d});
   endtask

   // Driver tasks: each starts and ends 1 time unit after a rising edge.
   task automatic idle(input int n);
      instr_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_alu(input logic [5:0] ctr, input logic [4:0] r, input logic w,
                         input logic [31:0] d);
      instr_valid = 1'b1; ALU_ctr = ctr; rd = r; reg_wr = w; exec_out = d;
      if (w) push_exp(r, d);
      @(negedge clk);
      chk1("alu_stall", cur_stall, 1'b0);
      chk1("alu_domult", cur_domult, 1'b0);
      chk1("err_flag", cur_err, err_exp[sel]);
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic do_alu_rand();
      logic [5:0] c;
      do c = 6'($urandom); while (c == 6'h0e || c == 6'h16);
      do_alu(c, 5'($urandom), 1'($urandom), $urandom);
   endtask

   // delay = WAIT cycles with done low before done rises; delay >= watchdog limit aborts.
   task automatic do_mult(input bit uns, input logic [4:0] r, input logic w, input int delay,
                          input bit stuck, input logic [31:0] prod);
      int lim;
      int n_low;
      lim = sel ? 8 : 64;
      mult_done = stuck;
      instr_valid = 1'b1; ALU_ctr = uns ? 6'h16 : 6'h0e; rd = r; reg_wr = w;
      exec_out = $urandom;
      @(negedge clk);
      chk1("mult_accept_stall", cur_stall, 1'b1);
      chk1("mult_accept_domult", cur_domult, 1'b0);
      @(posedge clk); #1;
      instr_valid = 1'($urandom); rd = 5'($urandom); reg_wr = 1'($urandom); exec_out = $urandom;
      @(negedge clk);
      chk1("issue_domult", cur_domult, 1'b1);
      chk1("issue_stall", cur_stall, 1'b1);
      @(posedge clk); #1;
      n_low = stuck ? 0 : ((delay < lim) ? delay : lim);
      for (int i = 0; i < n_low; i++) begin
         mult_done = 1'b0;
         instr_valid = 1'($urandom);
         @(negedge clk);
         chk1("wait_stall", cur_stall, 1'b1);
         chk1("wait_domult", cur_domult, 1'b0);
         chk1("wait_err", cur_err, err_exp[sel]);
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      if (stuck || delay < lim) begin
         mult_done = 1'b1; exec_out = prod;
         @(negedge clk);
         chk1("done_stall", cur_stall, 1'b0);
         chk1("done_domult", cur_domult, 1'b0);
         if (w) push_exp(r, prod);
         @(posedge clk); #1;
         mult_done = stuck;
      end else begin
         mult_done = 1'b0;
         err_exp[sel] = 1'b1;
         @(negedge clk);
         chk1("abort_stall", cur_stall, 1'b0);
         chk1("abort_err", cur_err, 1'b1);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      n_checks = 0; n_errors = 0;
      err_exp[0] = 1'b0; err_exp[1] = 1'b0;
      sel = 1'b0; reset = 1'b1; instr_valid = 1'b0; ALU_ctr = '0; reg_wr = 1'b0;
      rd = '0; exec_out = '0; mult_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_domult", domult0, 1'b0);
      chk1("rst_stall", stall0, 1'b0);
      chk1("rst_wb_en", wb_en0, 1'b0);
      chk32("rst_wb_rd", {27'd0, wb_rd0}, 32'd0);
      chk32("rst_wb_data", wb_data0, 32'd0);
      chk1("rst_err", err0, 1'b0);
      chk32("rst_state", {30'd0, dbg0}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single ALU op, then signed multiply completing 33 cycles after doMult
      do_alu(6'h20, 5'd5, 1'b1, 32'h0000_0007);
      idle(2);
      do_mult(1'b0, 5'd9, 1'b1, 32, 1'b0, 32'hFFFF_FFF4);
      idle(2);

      // Back-to-back ALU / unsigned mult / ALU
      do_alu(6'h20, 5'd1, 1'b1, 32'h1111_0001);
      do_mult(1'b1, 5'd2, 1'b1, 4, 1'b0, 32'd42);
      do_alu(6'h21, 5'd3, 1'b1, 32'h3333_0003);
      idle(2);

      // mult_done stuck high: ignored in IDLE, accepted on the first WAIT cycle
      mult_done = 1'b1;
      idle(3);
      do_mult(1'b1, 5'd12, 1'b1, 0, 1'b1, 32'h0BAD_F00D);
      mult_done = 1'b0;
      idle(2);

      // Watchdog on the 8-cycle instance, then normal operation continues
      sel = 1'b1;
      do_mult(1'b0, 5'd7, 1'b1, 100, 1'b0, 32'h0);
      do_alu(6'h20, 5'd8, 1'b1, 32'hCAFE_0008);
      do_mult(1'b1, 5'd10, 1'b1, 7, 1'b0, 32'h0000_1234);
      idle(2);
      sel = 1'b0;

      // Randomized traffic on the default instance
      for (int k = 0; k < 50; k++) begin
         case ($urandom_range(0, 3))
            0, 1: do_alu_rand();
            2: begin
               a = $urandom; b = $urandom;
               do_mult(1'($urandom), 5'($urandom), 1'($urandom), $urandom_range(0, 10),
                       1'b0, a * b);
            end
            default: idle($urandom_range(1, 2));
         endcase
      end
      idle(3);

      // Full-length watchdog on the default instance
      do_mult(1'b1, 5'd4, 1'b1, 200, 1'b0, 32'h0);
      do_alu_rand();
      idle(3);
      chk32("q0_drained", exp_q0.size(), 32'd0);
      chk32("q1_drained", exp_q1.size(), 32'd0);

      // Reset three cycles into WAIT discards the multiply and clears the error flags
      instr_valid = 1'b1; ALU_ctr = 6'h0e; rd = 5'd6; reg_wr = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      err_exp[0] = 1'b0; err_exp[1] = 1'b0;
      @(negedge clk);
      chk1("midrst_domult", domult0, 1'b0);
      chk1("midrst_stall", stall0, 1'b0);
      chk1("midrst_wb_en", wb_en0, 1'b0);
      chk1("midrst_err0", err0, 1'b0);
      chk1("midrst_err1", err1, 1'b0);
      @(posedge clk); #1;
      mult_done = 1'b1; exec_out = 32'hDEAD_BEEF;
      idle(1);
      mult_done = 1'b0;
      idle(2);
      do_alu(6'h20, 5'd11, 1'b1, 32'h0000_00AB);
      idle(3);
      chk32("q0_final", exp_q0.size(), 32'd0);
      chk32("q1_final", exp_q1.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_wb_ctrl.md
Name: mult_wb_ctrl

Overview:
- Sits directly downstream of the execute stage and consumes its 32-bit result.
- For ALU ops, registers the result into the writeback register.
- For multiply ops (ALU_ctr 6'h0e signed, 6'h16 unsigned), issues a one-cycle doMult pulse to execute and stalls the front end until execute reports mult_done. It then registers the product for writeback.
- A watchdog aborts a multiply that never completes.

Parameters:
- TIMEOUT, 64, maximum WAIT-state cycles before abort; legal range 2..255.
- CW, 8, watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  a decoded instruction is present at execute this cycle.
- ALU_ctr  input  6  ALU control of that instruction; must stay stable while stall=1.
- reg_wr  input  1  the instruction writes the register file.
- rd  input  5  destination register number.
- exec_out  input  32  execute stage result.
- mult_done  input  1  completion from execute (level; may stay high).
- doMult  output  1  multiply start to execute; registered.
- stall  output  1  hold PC/decode; combinational.
- wb_en  output  1  register-file write enable; registered.
- wb_rd  output  5  writeback register number; registered.
- wb_data  output  32  writeback data; registered.
- mult_err  output  1  sticky watchdog-abort flag; registered.

Behaviour:
- Synchronous, active-high reset on clk. Reset values: state=IDLE, doMult=0, wb_en=0, wb_rd=0, wb_data=0, mult_err=0, counter=0.
- Reset asserted mid-multiply drops doMult and stall in the cycle after the reset edge. The multiply in flight is discarded and no writeback occurs.
- is_mult = (ALU_ctr==6'h0e) | (ALU_ctr==6'h16).
- States: IDLE, ISSUE, WAIT.
- IDLE, instr_valid & !is_mult:
  - Next edge: wb_data<=exec_out, wb_rd<=rd, wb_en<=reg_wr.
  - Stays in IDLE. Latency is 1 cycle, with back-to-back throughput.
- IDLE, instr_valid & is_mult:
  - Next edge: held_rd<=rd, held_wr<=reg_wr, counter<=0, go to ISSUE.
  - wb_en<=0.
- IDLE, !instr_valid: wb_en<=0. mult_done is ignored.
- ISSUE: lasts exactly 1 cycle with doMult=1, then goes to WAIT. wb_en=0.
- WAIT, mult_done=1:
  - Next edge: wb_data<=exec_out, wb_rd<=held_rd, wb_en<=held_wr, go to IDLE.
  - If mult_done is already high on the first WAIT cycle, it is accepted.
- WAIT, mult_done=0:
  - counter increments each cycle.
  - When counter==TIMEOUT-1 and still not done: mult_err<=1, wb_en<=0, go to IDLE.
- doMult is high only while in ISSUE, i.e. exactly one cycle per multiply.
- stall = (IDLE & instr_valid & is_mult) | ISSUE | (WAIT & !mult_done). Stall therefore drops in the same cycle mult_done is seen, so the next instruction is presented on the following cycle.
- instr_valid while in ISSUE or WAIT is ignored (upstream is held by stall).
- wb_en is high for exactly one cycle per retired instruction that has reg_wr=1.
- mult_err clears only on reset. Later instructions continue to operate normally while it is set.
- A multiply followed immediately by another multiply costs a minimum of 3 cycles each (IDLE, ISSUE, WAIT with done).

Test Plan:
- ALU op: instr_valid=1, ALU_ctr=6'h20, exec_out=32'h0000_0007, rd=5, reg_wr=1 for one cycle -> next cycle wb_en=1, wb_rd=5, wb_data=7, stall never asserted, doMult never asserted.
- Signed mult: ALU_ctr=6'h0e, rd=9; mult_done rises 33 cycles after the doMult pulse with exec_out=32'hFFFF_FFF4 -> doMult high 1 cycle, stall high until the done cycle, one cycle later wb_en=1, wb_rd=9, wb_data=32'hFFFF_FFF4.
- Back-to-back: ALU op (rd=1) then unsigned mult (6'h16, rd=2, done after 5 cycles, exec_out=32'd42) then ALU op (rd=3) -> three single-cycle wb_en pulses in order with wb_rd 1, 2, 3 and the correct data; no lost or duplicated writes.
- Timeout: TIMEOUT=8, mult issued, mult_done held low -> mult_err=1 after 8 WAIT cycles, stall drops, wb_en stays 0; a following ALU op still writes back.
- Reset mid-op: reset asserted 3 cycles into WAIT -> next cycle doMult=0, stall=0, wb_en=0, mult_err=0; a later mult_done pulse causes no writeback.
- Stuck-high done: mult_done held 1 in IDLE, then a mult is issued -> doMult still pulses once, accepted on the first WAIT cycle, exactly one wb_en pulse.
